cpu_mem_dp: RTL and testbench
=============================

CPU_MEM_DP -- requirements
Module: cpu_mem_dp

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; DEPTH = 2^ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 = zero every word after reset; 0 = contents retained across reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 CLK  input  1  clock; all state changes on the rising edge.
REQ-006 RST_N  input  1  reset; asynchronous assertion, active low.
REQ-007 A_REQ  input  1  port A (fetch) read request.
REQ-008 A_ADDR  input  ADDR_W  port A read address.
REQ-009 A_RDATA  output  DATA_W  port A read data, registered.
REQ-010 A_VALID  output  1  one-cycle pulse: A_RDATA updated.
REQ-011 B_REQ  input  1  port B (data) request.
REQ-012 B_WE  input  1  port B direction: 1 write, 0 read.
REQ-013 B_ADDR  input  ADDR_W  port B address.
REQ-014 B_WDATA  input  DATA_W  port B write data.
REQ-015 B_RDATA  output  DATA_W  port B read data, registered.
REQ-016 B_VALID  output  1  one-cycle pulse: B read data updated, or B write done.
REQ-017 READY  output  1  high when requests are accepted.

Function
REQ-018 FSM states: INIT (clear sweep) and RUN; no other states.
REQ-019 During reset, state = INIT if CLEAR_ON_RESET=1, else RUN; sweep counter = 0.
REQ-020 INIT: each rising edge writes 0 to mem[counter] and increments counter; at the edge with counter = DEPTH-1, go to RUN; counter never wraps.
REQ-021 READY = 1 only in RUN (registered, from state).
REQ-022 A request is accepted when REQ=1 at a rising edge with READY=1; REQ in INIT is ignored: no VALID, no write.
REQ-023 Read latency is exactly 1 cycle: accepted read at edge N -> RDATA updated and VALID=1 after edge N, VALID=0 after edge N+1 unless another read is accepted.
REQ-024 RDATA holds its value until the next accepted read on the same port.
REQ-025 Accepted B write stores B_WDATA at B_ADDR at that edge; B_VALID pulses 1 cycle; B_RDATA unchanged.
REQ-026 Same-edge A read and B write to the same address: A_RDATA returns B_WDATA (write-first).
REQ-027 Ports are independent: A and B may each be accepted every cycle; back-to-back requests give back-to-back VALID pulses.
REQ-028 Address is full ADDR_W width; every value valid, no out-of-range case.

Reset
REQ-029 When RST_N goes low, A_RDATA=0, B_RDATA=0, A_VALID=0, B_VALID=0, READY=0 immediately; in-flight VALID pulses are dropped.
REQ-030 Reset asserted mid-INIT or mid-RUN restarts per REQ-019; with CLEAR_ON_RESET=0 no memory word is modified by reset.
REQ-031 With CLEAR_ON_RESET=0, READY=1 after the first rising edge following reset release.

Verification
REQ-032 CLEAR_ON_RESET=1, DATA_W=16, ADDR_W=8: release reset -> READY=0 for 256 edges, READY=1 after edge 256; a read of any of addresses 0/128/255 returns 0x0000.
REQ-033 B write 0x0132 to addr 10 at edge N, A read addr 10 at edge N+1 -> A_VALID=1 and A_RDATA=0x0132 after edge N+1; B_VALID pulse after edge N.
REQ-034 Same edge: A read addr 5 + B write 0xBEEF addr 5 -> A_RDATA=0xBEEF after that edge.
REQ-035 A_REQ=1 and B_REQ=1, B_WE=1, B_WDATA=0x1234, addr 3 at edge 10 of INIT -> no VALID pulses; after INIT, mem[3] reads 0x0000.
REQ-036 CLEAR_ON_RESET=0: write 0x012C to addr 7, pulse RST_N low while A_VALID=1 -> all outputs 0 at once; after release, A read addr 7 returns 0x012C.
REQ-037 A reads addr 255 then 0 on consecutive edges, holding 0x0190 and 0x0010 -> A_VALID high 2 cycles, A_RDATA = 0x0190 then 0x0010.

Source files
------------

// File: rtl/cpu_mem_dp.sv
// Dual-port CPU memory: port A fetch reads, port B data read/write.
// Optional zero-clear sweep after reset before requests are accepted.
module cpu_mem_dp #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic [ADDR_W-1:0] A_ADDR,
    output logic [DATA_W-1:0] A_RDATA,
    output logic              A_VALID,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              B_VALID,
    output logic              READY
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_e;
    localparam state_e RST_STATE = CLEAR_ON_RESET ? INIT : RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              a_acc, b_acc, b_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        a_acc     = ready_q & A_REQ;
        b_acc     = ready_q & B_REQ;
        b_wr      = b_acc & B_WE;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = b_wr;
        mem_waddr = B_ADDR;
        mem_wdata = B_WDATA;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == '1) state_d = RUN;
            else             cnt_d   = cnt_q + 1'b1;
        end
        ready_d = (state_d == RUN);

        // write-first bypass when B writes the word A is reading
        a_valid_d = a_acc;
        a_rdata_d = a_rdata_q;
        if (a_acc) begin
            if (b_wr && (B_ADDR == A_ADDR)) a_rdata_d = B_WDATA;
            else                            a_rdata_d = mem[A_ADDR];
        end

        b_valid_d = b_acc;
        b_rdata_d = b_rdata_q;
        if (b_acc && !B_WE) b_rdata_d = mem[B_ADDR];
    end

    // memory array holds no reset so contents can survive it
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign A_RDATA = a_rdata_q;
    assign A_VALID = a_valid_q;
    assign B_RDATA = b_rdata_q;
    assign B_VALID = b_valid_q;
    assign READY   = ready_q;
endmodule

// File: tb/tb_cpu_mem_dp.sv
// Directed bench for cpu_mem_dp: clearing instance and retaining instance.
module tb_cpu_mem_dp;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 1: CLEAR_ON_RESET=1
    logic        rst1, a_req1, b_req1, b_we1;
    logic [7:0]  a_addr1, b_addr1;
    logic [15:0] b_wdata1, a_rdata1, b_rdata1;
    logic        a_valid1, b_valid1, ready1;

    // instance 0: CLEAR_ON_RESET=0
    logic        rst0, a_req0, b_req0, b_we0;
    logic [7:0]  a_addr0, b_addr0;
    logic [15:0] b_wdata0, a_rdata0, b_rdata0;
    logic        a_valid0, b_valid0, ready0;

    int checks = 0;
    int failures = 0;

    cpu_mem_dp #(.DATA_W(16), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst1),
        .A_REQ(a_req1), .A_ADDR(a_addr1), .A_RDATA(a_rdata1), .A_VALID(a_valid1),
        .B_REQ(b_req1), .B_WE(b_we1), .B_ADDR(b_addr1), .B_WDATA(b_wdata1),
        .B_RDATA(b_rdata1), .B_VALID(b_valid1), .READY(ready1)
    );

    cpu_mem_dp #(.DATA_W(16), .ADDR_W(8), .CLEAR_ON_RESET(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst0),
        .A_REQ(a_req0), .A_ADDR(a_addr0), .A_RDATA(a_rdata0), .A_VALID(a_valid0),
        .B_REQ(b_req0), .B_WE(b_we0), .B_ADDR(b_addr0), .B_WDATA(b_wdata0),
        .B_RDATA(b_rdata0), .B_VALID(b_valid0), .READY(ready0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle1();
        a_req1 = 0; b_req1 = 0; b_we1 = 0;
    endtask

    task automatic idle0();
        a_req0 = 0; b_req0 = 0; b_we0 = 0;
    endtask

    initial begin
        rst1 = 0; rst0 = 0;
        idle1(); idle0();
        a_addr1 = 0; b_addr1 = 0; b_wdata1 = 0;
        a_addr0 = 0; b_addr0 = 0; b_wdata0 = 0;
        step(); step();
        chk("rst_ready1", {31'b0, ready1}, 0);
        chk("rst_avalid1", {31'b0, a_valid1}, 0);
        chk("rst_bvalid1", {31'b0, b_valid1}, 0);
        chk("rst_ardata1", {16'b0, a_rdata1}, 0);
        chk("rst_brdata1", {16'b0, b_rdata1}, 0);
        chk("rst_ready0", {31'b0, ready0}, 0);

        // ---- clearing instance: INIT sweep ----
        rst1 = 1;
        repeat (9) step();
        a_req1 = 1; a_addr1 = 3;
        b_req1 = 1; b_we1 = 1; b_addr1 = 3; b_wdata1 = 16'h1234;
        step();
        idle1();
        chk("init_avalid", {31'b0, a_valid1}, 0);
        chk("init_bvalid", {31'b0, b_valid1}, 0);
        chk("init_ready10", {31'b0, ready1}, 0);
        repeat (245) step();
        chk("init_ready255", {31'b0, ready1}, 0);
        step();
        chk("init_ready256", {31'b0, ready1}, 1);

        a_req1 = 1; a_addr1 = 0;
        b_req1 = 1; b_we1 = 0; b_addr1 = 128;
        step();
        chk("clr_a0_valid", {31'b0, a_valid1}, 1);
        chk("clr_a0_data", {16'b0, a_rdata1}, 0);
        chk("clr_b128_valid", {31'b0, b_valid1}, 1);
        chk("clr_b128_data", {16'b0, b_rdata1}, 0);
        a_addr1 = 255; b_addr1 = 3;
        step();
        chk("clr_a255_data", {16'b0, a_rdata1}, 0);
        chk("clr_b3_data", {16'b0, b_rdata1}, 0);
        idle1();
        step();
        chk("idle_avalid", {31'b0, a_valid1}, 0);
        chk("idle_bvalid", {31'b0, b_valid1}, 0);

        // write then read next edge
        b_req1 = 1; b_we1 = 1; b_addr1 = 10; b_wdata1 = 16'h0132;
        step();
        idle1();
        chk("wr10_bvalid", {31'b0, b_valid1}, 1);
        chk("wr10_brdata_hold", {16'b0, b_rdata1}, 0);
        chk("wr10_avalid", {31'b0, a_valid1}, 0);
        a_req1 = 1; a_addr1 = 10;
        step();
        idle1();
        chk("rd10_avalid", {31'b0, a_valid1}, 1);
        chk("rd10_adata", {16'b0, a_rdata1}, 32'h0132);
        chk("rd10_bvalid", {31'b0, b_valid1}, 0);

        // write-first collision
        a_req1 = 1; a_addr1 = 5;
        b_req1 = 1; b_we1 = 1; b_addr1 = 5; b_wdata1 = 16'hBEEF;
        step();
        idle1();
        chk("wf_adata", {16'b0, a_rdata1}, 32'hBEEF);
        chk("wf_avalid", {31'b0, a_valid1}, 1);
        chk("wf_bvalid", {31'b0, b_valid1}, 1);

        // back-to-back writes then back-to-back reads
        b_req1 = 1; b_we1 = 1; b_addr1 = 255; b_wdata1 = 16'h0190;
        step();
        b_addr1 = 0; b_wdata1 = 16'h0010;
        step();
        chk("b2b_wr_bvalid", {31'b0, b_valid1}, 1);
        idle1();
        a_req1 = 1; a_addr1 = 255;
        step();
        chk("b2b_rd1_valid", {31'b0, a_valid1}, 1);
        chk("b2b_rd1_data", {16'b0, a_rdata1}, 32'h0190);
        a_addr1 = 0;
        step();
        idle1();
        chk("b2b_rd2_valid", {31'b0, a_valid1}, 1);
        chk("b2b_rd2_data", {16'b0, a_rdata1}, 32'h0010);
        step();
        chk("b2b_end_valid", {31'b0, a_valid1}, 0);
        chk("b2b_hold_data", {16'b0, a_rdata1}, 32'h0010);

        // B read, then B write must leave B_RDATA alone
        b_req1 = 1; b_we1 = 0; b_addr1 = 10;
        step();
        chk("brd10_data", {16'b0, b_rdata1}, 32'h0132);
        b_we1 = 1; b_addr1 = 11; b_wdata1 = 16'h5555;
        step();
        idle1();
        chk("bwr_hold_data", {16'b0, b_rdata1}, 32'h0132);
        b_req1 = 1; b_we1 = 0; b_addr1 = 11;
        step();
        idle1();
        chk("brd11_data", {16'b0, b_rdata1}, 32'h5555);

        // mid-RUN reset restarts the sweep
        #2 rst1 = 0;
        #1;
        chk("midrun_ready", {31'b0, ready1}, 0);
        chk("midrun_brdata", {16'b0, b_rdata1}, 0);
        @(negedge clk);
        rst1 = 1;
        step();
        chk("resweep_ready", {31'b0, ready1}, 0);

        // ---- retaining instance ----
        rst0 = 1;
        chk("ret_ready_pre", {31'b0, ready0}, 0);
        step();
        chk("ret_ready_1edge", {31'b0, ready0}, 1);
        b_req0 = 1; b_we0 = 1; b_addr0 = 7; b_wdata0 = 16'h012C;
        step();
        idle0();
        chk("ret_wr_bvalid", {31'b0, b_valid0}, 1);
        a_req0 = 1; a_addr0 = 7;
        step();
        idle0();
        chk("ret_rd_avalid", {31'b0, a_valid0}, 1);
        chk("ret_rd_adata", {16'b0, a_rdata0}, 32'h012C);
        #2 rst0 = 0;
        #1;
        chk("ret_rst_avalid", {31'b0, a_valid0}, 0);
        chk("ret_rst_adata", {16'b0, a_rdata0}, 0);
        chk("ret_rst_ready", {31'b0, ready0}, 0);
        chk("ret_rst_bvalid", {31'b0, b_valid0}, 0);
        @(negedge clk);
        step();
        rst0 = 1;
        step();
        chk("ret_ready_after", {31'b0, ready0}, 1);
        a_req0 = 1; a_addr0 = 7;
        step();
        idle0();
        chk("ret_kept_avalid", {31'b0, a_valid0}, 1);
        chk("ret_kept_adata", {16'b0, a_rdata0}, 32'h012C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
